floo_chan_credit_mux: RTL and testbench

FLOO_CHAN_CREDIT_MUX -- requirements
Module: floo_chan_credit_mux

---
 rtl/floo_chan_credit_mux.sv | 133 +++++++++++++
 tb/tb_floo_chan_credit_mux.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/floo_chan_credit_mux.sv
// Credit-based round-robin multiplexer of NumChan logical channels onto one physical link.
// Optional per-channel sent-flit counters are built only when FLOO_CHAN_MUX_PERF_EN is defined.
module floo_chan_credit_mux #(
  parameter int unsigned NumChan     = 3,
  parameter int unsigned FlitWidth   = 64,
  parameter int unsigned CreditDepth = 4,
  localparam int unsigned ChanW      = $clog2(NumChan),
  localparam int unsigned CntW       = $clog2(CreditDepth + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumChan-1:0]                 valid_i,
  output logic [NumChan-1:0]                 ready_o,
  input  logic [NumChan-1:0][FlitWidth-1:0]  data_i,
  output logic                               link_valid_o,
  output logic [ChanW-1:0]                   link_chan_o,
  output logic [FlitWidth-1:0]               link_data_o,
  input  logic                               credit_valid_i,
  input  logic [ChanW-1:0]                   credit_chan_i,
  output logic                               credit_err_o,
  output logic [NumChan-1:0][15:0]           perf_cnt_o
);

  localparam logic [CntW-1:0] CreditFull = CntW'(CreditDepth);

  logic [NumChan-1:0][CntW-1:0] credit_q;
  logic [ChanW-1:0]             rr_ptr_q;
  logic                         err_q;

  logic [NumChan-1:0] eligible;
  logic [NumChan-1:0] ret;
  logic               ret_ok;
  logic               chan_bad;
  logic               overflow;
  logic               grant_vld_p0;
  logic [ChanW-1:0]   grant_idx_p0;

  // Stage p0: eligibility, round-robin arbitration and credit-return decode
  always_comb begin
    ret_ok   = credit_valid_i && (int'(credit_chan_i) < int'(NumChan));
    chan_bad = credit_valid_i && !ret_ok;
    for (int i = 0; i < NumChan; i++) begin
      eligible[i] = valid_i[i] && (credit_q[i] != '0);
      ret[i]      = ret_ok && (credit_chan_i == ChanW'(i));
    end
  end

  // Search starts one past the last granted index and wraps around
  always_comb begin
    int idx;
    idx          = 0;
    grant_vld_p0 = 1'b0;
    grant_idx_p0 = '0;
    for (int k = 1; k <= NumChan; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= int'(NumChan)) idx = idx - int'(NumChan);
      if (!grant_vld_p0 && eligible[idx]) begin
        grant_vld_p0 = 1'b1;
        grant_idx_p0 = ChanW'(idx);
      end
    end
  end

  always_comb begin
    overflow = 1'b0;
    for (int i = 0; i < NumChan; i++) begin
      ready_o[i] = grant_vld_p0 && (grant_idx_p0 == ChanW'(i));
      if (ret[i] && !ready_o[i] && (credit_q[i] == CreditFull)) overflow = 1'b1;
    end
  end

  // A send and a return on the same channel cancel out; an overflowing return is dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumChan; i++) credit_q[i] <= CreditFull;
      rr_ptr_q <= ChanW'(NumChan - 1);
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NumChan; i++) begin
        if (ready_o[i] && !ret[i]) begin
          credit_q[i] <= credit_q[i] - 1'b1;
        end else if (ret[i] && !ready_o[i] && (credit_q[i] != CreditFull)) begin
          credit_q[i] <= credit_q[i] + 1'b1;
        end
      end
      if (grant_vld_p0) rr_ptr_q <= grant_idx_p0;
      if (chan_bad || overflow) err_q <= 1'b1;
    end
  end

  logic                 vld_p1;
  logic [ChanW-1:0]     chan_p1;
  logic [FlitWidth-1:0] data_p1;

  // Stage p1: registered link flit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1  <= 1'b0;
      chan_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= grant_vld_p0;
      if (grant_vld_p0) begin
        chan_p1 <= grant_idx_p0;
        data_p1 <= data_i[grant_idx_p0];
      end
    end
  end

  assign link_valid_o = vld_p1;
  assign link_chan_o  = chan_p1;
  assign link_data_o  = data_p1;
  assign credit_err_o = err_q;

`ifdef FLOO_CHAN_MUX_PERF_EN
  logic [NumChan-1:0][15:0] perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else begin
      for (int i = 0; i < NumChan; i++) begin
        if (ready_o[i] && (perf_q[i] != 16'hFFFF)) perf_q[i] <= perf_q[i] + 16'd1;
      end
    end
  end

  assign perf_cnt_o = perf_q;
`else
  assign perf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_floo_chan_credit_mux.sv
// Vector-table bench for floo_chan_credit_mux (NumChan=3, FlitWidth=64, CreditDepth=4).
// Expected link flits are queued when a grant is expected and popped when the link presents them.
module tb_floo_chan_credit_mux;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic [2:0]            valid_i = '0;
  logic [2:0]            ready_o;
  logic [2:0][63:0]      data_i = '0;
  logic                  link_valid_o;
  logic [1:0]            link_chan_o;
  logic [63:0]           link_data_o;
  logic                  credit_valid_i = 1'b0;
  logic [1:0]            credit_chan_i = '0;
  logic                  credit_err_o;
  logic [2:0][15:0]      perf_cnt_o;

  floo_chan_credit_mux #(
    .NumChan    (3),
    .FlitWidth  (64),
    .CreditDepth(4)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .data_i        (data_i),
    .link_valid_o  (link_valid_o),
    .link_chan_o   (link_chan_o),
    .link_data_o   (link_data_o),
    .credit_valid_i(credit_valid_i),
    .credit_chan_i (credit_chan_i),
    .credit_err_o  (credit_err_o),
    .perf_cnt_o    (perf_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       rst;
    logic [2:0] valid;
    logic       cv;
    logic [1:0] cchan;
    logic [2:0] exp_ready;
    logic       exp_err;
  } vec_t;

  typedef struct packed {
    logic [1:0]  chan;
    logic [63:0] data;
  } flit_t;

  localparam int NVEC  = 37;
  localparam int NPART = 31;

  vec_t        tbl [NVEC];
  flit_t       sb_q [$];
  int          nvec = 0;
  int          nerr = 0;
  logic [15:0] perf_model [3];

  function automatic vec_t mk(logic r, logic [2:0] v, logic cv, logic [1:0] cc,
                              logic [2:0] er, logic ee);
    vec_t t;
    t.rst = r; t.valid = v; t.cv = cv; t.cchan = cc; t.exp_ready = er; t.exp_err = ee;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_perf(input string name);
    for (int c = 0; c < 3; c++) begin
`ifdef FLOO_CHAN_MUX_PERF_EN
      check(name, 64'(perf_cnt_o[c]), 64'(perf_model[c]));
`else
      check(name, 64'(perf_cnt_o[c]), 64'd0);
`endif
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    for (int c = 0; c < 3; c++) perf_model[c] = '0;
  endtask

  // Entered and left at posedge+1
  task automatic do_reset();
    valid_i        = '0;
    credit_valid_i = 1'b0;
    rst_ni         = 1'b0;
    model_reset();
    #1;
    check("rst_link_valid_async", 64'(link_valid_o), 64'd0);
    @(negedge clk_i);
    check("rst_link_chan", 64'(link_chan_o), 64'd0);
    check("rst_link_data", link_data_o, 64'd0);
    check("rst_credit_err", 64'(credit_err_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd0);
    check_perf("rst_perf");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_link(input string name);
    flit_t f;
    if (sb_q.size() > 0) begin
      f = sb_q.pop_front();
      check({name, "_valid"}, 64'(link_valid_o), 64'd1);
      check({name, "_chan"}, 64'(link_chan_o), 64'(f.chan));
      check({name, "_data"}, link_data_o, f.data);
    end else begin
      check({name, "_valid"}, 64'(link_valid_o), 64'd0);
    end
  endtask

  // Entered and left at posedge+1
  task automatic apply_row(input int r);
    vec_t  v;
    flit_t f;
    v = tbl[r];
    if (v.rst) do_reset();
    valid_i        = v.valid;
    credit_valid_i = v.cv;
    credit_chan_i  = v.cchan;
    for (int c = 0; c < 3; c++) data_i[c] = {$urandom(), $urandom()};
    @(negedge clk_i);
    check($sformatf("row%0d_ready", r), 64'(ready_o), 64'(v.exp_ready));
    for (int c = 0; c < 3; c++) begin
      if (v.exp_ready[c]) begin
        f.chan = 2'(c);
        f.data = data_i[c];
        sb_q.push_back(f);
        if (perf_model[c] != 16'hFFFF) perf_model[c]++;
      end
    end
    @(posedge clk_i);
    #1;
    check_link($sformatf("row%0d_link", r));
    check($sformatf("row%0d_err", r), 64'(credit_err_o), 64'(v.exp_err));
    check_perf($sformatf("row%0d_perf", r));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // All channels busy, credit for the granted channel returned in the same cycle
    tbl[0]  = mk(1, 3'b111, 1, 2'd0, 3'b001, 0);
    tbl[1]  = mk(0, 3'b111, 1, 2'd1, 3'b010, 0);
    tbl[2]  = mk(0, 3'b111, 1, 2'd2, 3'b100, 0);
    tbl[3]  = mk(0, 3'b111, 1, 2'd0, 3'b001, 0);
    tbl[4]  = mk(0, 3'b111, 1, 2'd1, 3'b010, 0);
    tbl[5]  = mk(0, 3'b111, 1, 2'd2, 3'b100, 0);
    // ch0 down to 2, then send + return together keeps it at 2
    tbl[6]  = mk(0, 3'b001, 0, 2'd0, 3'b001, 0);
    tbl[7]  = mk(0, 3'b001, 0, 2'd0, 3'b001, 0);
    tbl[8]  = mk(0, 3'b001, 1, 2'd0, 3'b001, 0);
    tbl[9]  = mk(0, 3'b001, 0, 2'd0, 3'b001, 0);
    tbl[10] = mk(0, 3'b001, 0, 2'd0, 3'b001, 0);
    tbl[11] = mk(0, 3'b001, 0, 2'd0, 3'b000, 0);
    // ch2 drained; returned credit usable only from the following cycle
    tbl[12] = mk(0, 3'b100, 0, 2'd0, 3'b100, 0);
    tbl[13] = mk(0, 3'b100, 0, 2'd0, 3'b100, 0);
    tbl[14] = mk(0, 3'b100, 0, 2'd0, 3'b100, 0);
    tbl[15] = mk(0, 3'b100, 0, 2'd0, 3'b100, 0);
    tbl[16] = mk(0, 3'b100, 1, 2'd2, 3'b000, 0);
    tbl[17] = mk(0, 3'b100, 0, 2'd0, 3'b100, 0);
    tbl[18] = mk(0, 3'b100, 0, 2'd0, 3'b000, 0);
    // ch1 overflow sets the sticky flag
    tbl[19] = mk(0, 3'b000, 1, 2'd1, 3'b000, 1);
    tbl[20] = mk(0, 3'b000, 0, 2'd0, 3'b000, 1);
    tbl[21] = mk(0, 3'b010, 0, 2'd0, 3'b010, 1);
    tbl[22] = mk(0, 3'b000, 1, 2'd1, 3'b000, 1);
    // Only ch1 valid for 6 cycles, no returns: 4 flits then stall
    tbl[23] = mk(1, 3'b010, 0, 2'd0, 3'b010, 0);
    tbl[24] = mk(0, 3'b010, 0, 2'd0, 3'b010, 0);
    tbl[25] = mk(0, 3'b010, 0, 2'd0, 3'b010, 0);
    tbl[26] = mk(0, 3'b010, 0, 2'd0, 3'b010, 0);
    tbl[27] = mk(0, 3'b010, 0, 2'd0, 3'b000, 0);
    tbl[28] = mk(0, 3'b010, 0, 2'd0, 3'b000, 0);
    // Out-of-range credit channel is ignored but flagged
    tbl[29] = mk(0, 3'b000, 1, 2'd3, 3'b000, 1);
    tbl[30] = mk(0, 3'b001, 0, 2'd0, 3'b001, 1);
    // After mid-flight reset: ch0 first, full 4 credits, ch1 full
    tbl[31] = mk(0, 3'b111, 0, 2'd0, 3'b001, 0);
    tbl[32] = mk(0, 3'b001, 0, 2'd0, 3'b001, 0);
    tbl[33] = mk(0, 3'b001, 0, 2'd0, 3'b001, 0);
    tbl[34] = mk(0, 3'b001, 0, 2'd0, 3'b001, 0);
    tbl[35] = mk(0, 3'b001, 0, 2'd0, 3'b000, 0);
    tbl[36] = mk(0, 3'b010, 0, 2'd0, 3'b010, 0);

    model_reset();
    @(posedge clk_i);
    #1;
    for (int r = 0; r < NPART; r++) apply_row(r);

    // Handshake on ch0, then reset asserted right after the flit is registered
    valid_i        = 3'b001;
    credit_valid_i = 1'b0;
    data_i[0]      = 64'hDEAD_BEEF_0123_4567;
    @(negedge clk_i);
    check("midrst_ready", 64'(ready_o), 64'b001);
    @(posedge clk_i);
    #1;
    check("midrst_link_valid", 64'(link_valid_o), 64'd1);
    check("midrst_link_data", link_data_o, 64'hDEAD_BEEF_0123_4567);
    valid_i = '0;
    rst_ni  = 1'b0;
    model_reset();
    #1;
    check("midrst_drop", 64'(link_valid_o), 64'd0);
    check("midrst_err_clr", 64'(credit_err_o), 64'd0);
    check_perf("midrst_perf");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("midrst_idle", 64'(link_valid_o), 64'd0);

    for (int r = NPART; r < NVEC; r++) apply_row(r);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
